inst_fetch: RTL and testbench

Instruction-fetch stage of the pipelined CPU, upstream of the instruction decoder. It owns the word-addressed program counter and issues requests to instruction memory through a ready handshake. It delivers each 32-bit instruction plus its address through the IF/ID pipeline register. It absorbs downstream stalls with a one-entry hold buffer and squashes wrong-path fetches on branch/jump redirect.

---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/inst_fetch_if.sv | 16 +
 rtl/inst_fetch.sv | 123 ++++++++++++
 tb/tb_inst_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: NOP encoding, base opcodes used by fetch and decode,
// and the fetch-stage state encoding.
package inst_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus. The fetch stage is the master and
// the memory is the slave.
interface inst_fetch_if #(
  parameter int PC_W = 32
);
  import inst_fetch_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: word-addressed PC, ready-handshake memory requests, IF/ID
// register, one-entry hold buffer for stalls and squash of wrong-path fetches.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  inst_fetch_if.master    imem,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc_out,
  output logic            valid
);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] req_addr_reg, req_addr_next;
  logic [31:0]     inst_reg, inst_next;
  logic [PC_W-1:0] pc_out_reg, pc_out_next;
  logic            valid_reg, valid_next;
  logic [31:0]     hbuf_inst_reg, hbuf_inst_next;
  logic [PC_W-1:0] hbuf_pc_reg, hbuf_pc_next;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_reg + PC_W'(1);

  // No request while reset is held, so a response landing then is ignored.
  assign imem.imem_req  = (state_reg != HOLD) && !rst;
  assign imem.imem_addr = req_addr_reg;

  assign inst   = inst_reg;
  assign pc_out = pc_out_reg;
  assign valid  = valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      req_addr_reg  <= RESET_PC;
      inst_reg      <= NOP_INST;
      pc_out_reg    <= '0;
      valid_reg     <= 1'b0;
      hbuf_inst_reg <= NOP_INST;
      hbuf_pc_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_addr_reg  <= req_addr_next;
      inst_reg      <= inst_next;
      pc_out_reg    <= pc_out_next;
      valid_reg     <= valid_next;
      hbuf_inst_reg <= hbuf_inst_next;
      hbuf_pc_reg   <= hbuf_pc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_addr_next  = req_addr_reg;
    inst_next      = inst_reg;
    pc_out_next    = pc_out_reg;
    valid_next     = valid_reg;
    hbuf_inst_next = hbuf_inst_reg;
    hbuf_pc_next   = hbuf_pc_reg;

    // A redirect flushes IF/ID regardless of stall; pc_out is left as is.
    if (br_taken) begin
      inst_next  = NOP_INST;
      valid_next = 1'b0;
    end

    case (state_reg)
      FETCH: begin
        if (br_taken) begin
          pc_next = br_target;
          if (imem.imem_ready) req_addr_next = br_target;
          else                 state_next    = SQUASH;
        end else if (imem.imem_ready) begin
          pc_next = pc_inc;
          if (!stall || !valid_reg) begin
            inst_next     = imem.imem_rdata;
            pc_out_next   = req_addr_reg;
            valid_next    = 1'b1;
            req_addr_next = pc_inc;
          end else begin
            hbuf_inst_next = imem.imem_rdata;
            hbuf_pc_next   = req_addr_reg;
            state_next     = HOLD;
          end
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_next       = br_target;
          req_addr_next = br_target;
          state_next    = FETCH;
        end else if (!stall) begin
          inst_next     = hbuf_inst_reg;
          pc_out_next   = hbuf_pc_reg;
          valid_next    = 1'b1;
          req_addr_next = pc_reg;
          state_next    = FETCH;
        end
      end
      SQUASH: begin
        // The outstanding wrong-path response is consumed and dropped here.
        if (br_taken) pc_next = br_target;
        if (imem.imem_ready) begin
          req_addr_next = br_taken ? br_target : pc_reg;
          state_next    = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, hand-written reset/wrap corners,
// and a randomized run against a program-order reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br, rdy;
  logic [31:0] tgt;
  logic [31:0] inst, pc_out;
  logic        valid;
  logic [31:0] inst2, pc_out2;
  logic        valid2;
  logic        stall2, br2;
  logic [31:0] tgt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  inst_fetch_if #(.PC_W(32)) bus ();
  inst_fetch_if #(.PC_W(32)) bus2 ();

  assign bus.imem_ready  = rdy;
  assign bus.imem_rdata  = word(bus.imem_addr);
  assign bus2.imem_ready = 1'b1;
  assign bus2.imem_rdata = word(bus2.imem_addr);

  inst_fetch #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(bus.master), .stall(stall), .br_taken(br),
    .br_target(tgt), .inst(inst), .pc_out(pc_out), .valid(valid)
  );

  inst_fetch #(.PC_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .imem(bus2.master), .stall(stall2), .br_taken(br2),
    .br_target(tgt2), .inst(inst2), .pc_out(pc_out2), .valid(valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy, stall, br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic q, input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t x;
    x.rdy = r; x.stall = s; x.br = b; x.tgt = t;
    x.req = q; x.addr = a; x.vld = v; x.pc = p;
    return x;
  endfunction

  vec_t tbl[21];

  // Reference-model state for the random run
  logic [31:0] exp_pc;
  logic        p_req, p_rdy, p_br, p_stall, p_valid;
  logic [31:0] p_addr, p_tgt, p_pc_out, p_inst;
  int          lat, ndeliv;
  bit          first;

  initial begin
    // outputs: req, addr, valid, pc_out during the row; inputs applied that cycle
    tbl[0]  = mk(1, 0, 0, 0,     1, 32'h00, 0, 32'h00);
    tbl[1]  = mk(1, 0, 0, 0,     1, 32'h01, 1, 32'h00);
    tbl[2]  = mk(1, 0, 0, 0,     1, 32'h02, 1, 32'h01);
    tbl[3]  = mk(1, 0, 0, 0,     1, 32'h03, 1, 32'h02);
    tbl[4]  = mk(1, 0, 0, 0,     1, 32'h04, 1, 32'h03);
    tbl[5]  = mk(1, 1, 0, 0,     1, 32'h05, 1, 32'h04);
    tbl[6]  = mk(0, 1, 0, 0,     0, 32'h05, 1, 32'h04);
    tbl[7]  = mk(0, 1, 0, 0,     0, 32'h05, 1, 32'h04);
    tbl[8]  = mk(0, 0, 0, 0,     0, 32'h05, 1, 32'h04);
    tbl[9]  = mk(0, 0, 0, 0,     1, 32'h06, 1, 32'h05);
    tbl[10] = mk(0, 0, 0, 0,     1, 32'h06, 1, 32'h05);
    tbl[11] = mk(0, 0, 0, 0,     1, 32'h06, 1, 32'h05);
    tbl[12] = mk(0, 0, 0, 0,     1, 32'h06, 1, 32'h05);
    tbl[13] = mk(1, 0, 0, 0,     1, 32'h06, 1, 32'h05);
    tbl[14] = mk(0, 0, 1, 32'h40, 1, 32'h07, 1, 32'h06);
    tbl[15] = mk(0, 0, 0, 0,     1, 32'h07, 0, 32'h06);
    tbl[16] = mk(1, 0, 0, 0,     1, 32'h07, 0, 32'h06);
    tbl[17] = mk(1, 0, 0, 0,     1, 32'h40, 0, 32'h06);
    tbl[18] = mk(1, 1, 1, 32'h80, 1, 32'h41, 1, 32'h40);
    tbl[19] = mk(1, 0, 0, 0,     1, 32'h80, 0, 32'h40);
    tbl[20] = mk(0, 0, 0, 0,     1, 32'h81, 1, 32'h80);

    rst = 1'b1; stall = 1'b0; br = 1'b0; rdy = 1'b0; tgt = '0;
    stall2 = 1'b0; br2 = 1'b0; tgt2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, bus.imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].vld});
      chk($sformatf("v%0d_pc_out", i), pc_out, tbl[i].pc);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].vld ? word(tbl[i].pc) : 32'd0);
      if (i == 0) chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFF);
      if (i == 1) begin
        chk("wrap_addr1", bus2.imem_addr, 32'h0000_0000);
        chk("wrap_pc_out", pc_out2, 32'hFFFF_FFFF);
        chk("wrap_valid", {31'd0, valid2}, 32'd1);
        chk("wrap_inst", inst2, word(32'hFFFF_FFFF));
      end
      rdy = tbl[i].rdy; stall = tbl[i].stall; br = tbl[i].br; tgt = tbl[i].tgt;
      $display("vec %0d: rdy=%0d stall=%0d br=%0d addr=%h valid=%0d pc_out=%h",
               i, tbl[i].rdy, tbl[i].stall, tbl[i].br, bus.imem_addr, valid, pc_out);
      @(negedge clk);
    end

    // Reset while a fetched word sits in the hold buffer
    #1;
    rdy = 1'b1; stall = 1'b1; br = 1'b0;
    @(negedge clk); #1;
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    rdy = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    chk("hold_rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    #1;
    chk("hold_rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("hold_rst_addr", bus.imem_addr, 32'd0);
    rdy = 1'b1;
    @(negedge clk); #1;
    chk("hold_rst_pc_out", pc_out, 32'd0);
    chk("hold_rst_inst", inst, word(32'd0));
    $display("mid-hold reset: first fetch pc_out=%h", pc_out);

    // Randomized run: memory with random latency, random stalls and redirects
    rdy = 1'b0; stall = 1'b0; br = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'd0; lat = 0; ndeliv = 0; first = 1'b1;
    p_req = 0; p_rdy = 0; p_br = 0; p_stall = 0; p_valid = 0;
    p_addr = 0; p_tgt = 0; p_pc_out = 0; p_inst = 0;
    for (int n = 0; n < 3000; n++) begin
      #1;
      if (!first) begin
        if (p_req && !p_rdy) begin
          chk("rnd_req_held", {31'd0, bus.imem_req}, 32'd1);
          chk("rnd_addr_stable", bus.imem_addr, p_addr);
        end
        if (!valid) chk("rnd_nop", inst, 32'd0);
        if (p_br) begin
          chk("rnd_flush_valid", {31'd0, valid}, 32'd0);
          chk("rnd_flush_pc_out", pc_out, p_pc_out);
          exp_pc = p_tgt;
        end else if (p_valid && p_stall) begin
          chk("rnd_stall_valid", {31'd0, valid}, 32'd1);
          chk("rnd_stall_pc_out", pc_out, p_pc_out);
          chk("rnd_stall_inst", inst, p_inst);
        end else if (valid && (!p_valid || pc_out != p_pc_out)) begin
          chk("rnd_order_pc", pc_out, exp_pc);
          chk("rnd_data", inst, word(pc_out));
          $display("deliver %0d: pc_out=%h inst=%h", ndeliv, pc_out, inst);
          exp_pc = pc_out + 32'd1;
          ndeliv++;
        end
      end
      first = 1'b0;
      if (bus.imem_req) begin
        if (lat == 0) begin
          rdy = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          rdy = 1'b0;
          lat--;
        end
      end else begin
        rdy = 1'b0;
      end
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 15) == 0);
      tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
      p_req = bus.imem_req; p_rdy = rdy; p_br = br; p_stall = stall; p_valid = valid;
      p_addr = bus.imem_addr; p_tgt = tgt; p_pc_out = pc_out; p_inst = inst;
      @(negedge clk);
    end
    chk("rnd_deliveries", {31'd0, (ndeliv >= 200)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
